// File: rtl/ctrl_in_arb_pkg.sv
// Shared types for the control-input PIO read arbiter.
// State encoding, latency counter width, master indices.
package ctrl_in_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    localparam int CNT_W = 3;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker with its own priority pointer.
// Ports: clk, reset_n, req[1:0], update/winner (pointer flip), gnt, any_req.
module rr_arb2
    import ctrl_in_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       winner,
    output logic       gnt,
    output logic       any_req
);

    logic ptr;

    // Pointer moves to the side that just lost, so contention alternates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= M0;
        end else if (update) begin
            ptr <= ~winner;
        end
    end

    always_comb begin
        any_req = |req;
        gnt     = M0;
        if (req == 2'b11) begin
            gnt = ptr;
        end else if (req[1]) begin
            gnt = M1;
        end
    end

endmodule

// File: rtl/ctrl_in_read_arbiter.sv
// Shares one PIO read slave between two Avalon-MM read masters (m0, m1).
// Ports: clk, reset_n, mX_read/address/waitrequest/readdata, s_address, s_readdata, grant.
module ctrl_in_read_arbiter
    import ctrl_in_arb_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 32,
    parameter int SLV_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_read,
    input  logic [ADDR_W-1:0] m0_address,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_read,
    input  logic [ADDR_W-1:0] m1_address,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              grant
);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pick;
    logic             any_req;

    rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({m1_read, m0_read}),
        .update  (state == ST_DONE),
        .winner  (grant),
        .gnt     (pick),
        .any_req (any_req)
    );

    // The data capture and the waitrequest-low pulse are loaded on the
    // same edge that enters DONE, so both are valid for that one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            grant          <= M0;
            s_address      <= '0;
            m0_waitrequest <= 1'b1;
            m1_waitrequest <= 1'b1;
            m0_readdata    <= '0;
            m1_readdata    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        s_address <= pick ? m1_address : m0_address;
                        cnt       <= CNT_W'(SLV_LATENCY);
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        if (grant == M1) begin
                            m1_readdata    <= s_readdata;
                            m1_waitrequest <= 1'b0;
                        end else begin
                            m0_readdata    <= s_readdata;
                            m0_waitrequest <= 1'b0;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    m0_waitrequest <= 1'b1;
                    m1_waitrequest <= 1'b1;
                    m0_readdata    <= '0;
                    m1_readdata    <= '0;
                    state          <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_in_read_arbiter.sv
// Directed bench for ctrl_in_read_arbiter.
// Vector table for single transactions plus hand sequences for corners.
module tb_ctrl_in_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_read, m1_read;
    logic [1:0]  m0_address, m1_address;
    logic        m0_wr, m1_wr;
    logic [31:0] m0_rd, m1_rd;
    logic [1:0]  s_address;
    logic [31:0] s_readdata;
    logic        grant;

    logic        l3_m0_read, l3_m1_read;
    logic [1:0]  l3_m0_address, l3_m1_address;
    logic        l3_m0_wr, l3_m1_wr;
    logic [31:0] l3_m0_rd, l3_m1_rd;
    logic [1:0]  l3_s_address;
    logic [31:0] l3_s_readdata;
    logic        l3_grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_word(input logic [1:0] a);
        case (a)
            2'd0:    return 32'h0000_00A5;
            2'd1:    return 32'h1234_5678;
            2'd2:    return 32'hDEAD_BEEF;
            default: return 32'h0000_00C3;
        endcase
    endfunction

    assign s_readdata    = slave_word(s_address);
    assign l3_s_readdata = slave_word(l3_s_address);

    ctrl_in_read_arbiter #(.ADDR_W(2), .DATA_W(32), .SLV_LATENCY(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_read(m0_read), .m0_address(m0_address),
        .m0_waitrequest(m0_wr), .m0_readdata(m0_rd),
        .m1_read(m1_read), .m1_address(m1_address),
        .m1_waitrequest(m1_wr), .m1_readdata(m1_rd),
        .s_address(s_address), .s_readdata(s_readdata),
        .grant(grant)
    );

    ctrl_in_read_arbiter #(.ADDR_W(2), .DATA_W(32), .SLV_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .m0_read(l3_m0_read), .m0_address(l3_m0_address),
        .m0_waitrequest(l3_m0_wr), .m0_readdata(l3_m0_rd),
        .m1_read(l3_m1_read), .m1_address(l3_m1_address),
        .m1_waitrequest(l3_m1_wr), .m1_readdata(l3_m1_rd),
        .s_address(l3_s_address), .s_readdata(l3_s_readdata),
        .grant(l3_grant)
    );

    typedef struct {
        logic        r0;
        logic        r1;
        logic [1:0]  a0;
        logic [1:0]  a1;
        logic        eg;
        logic [1:0]  ea;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until some waitrequest drops, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            cyc++;
            if (!m0_wr || !m1_wr) return;
        end
        check("done_timeout", 32'(cyc), 32'(0));
    endtask

    task automatic check_xact(input string tag, input logic eg,
                              input logic [1:0] ea, input logic [31:0] ed,
                              input int el, input int cyc);
        check({tag, "_lat"}, 32'(cyc), 32'(el));
        check({tag, "_grant"}, 32'(grant), 32'(eg));
        check({tag, "_saddr"}, 32'(s_address), 32'(ea));
        if (eg) begin
            check({tag, "_win_wr"}, 32'(m1_wr), 32'(0));
            check({tag, "_win_rd"}, m1_rd, ed);
            check({tag, "_los_wr"}, 32'(m0_wr), 32'(1));
            check({tag, "_los_rd"}, m0_rd, 32'(0));
        end else begin
            check({tag, "_win_wr"}, 32'(m0_wr), 32'(0));
            check({tag, "_win_rd"}, m0_rd, ed);
            check({tag, "_los_wr"}, 32'(m1_wr), 32'(1));
            check({tag, "_los_rd"}, m1_rd, 32'(0));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        check("rst_m0_wr", 32'(m0_wr), 32'(1));
        check("rst_m1_wr", 32'(m1_wr), 32'(1));
        check("rst_m0_rd", m0_rd, 32'(0));
        check("rst_m1_rd", m1_rd, 32'(0));
        check("rst_saddr", 32'(s_address), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        int cyc;
        int lows;

        vecs[0] = '{1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 32'h0000_00A5};
        vecs[1] = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 2'd1, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 2'd3, 32'h0000_00C3};
        vecs[3] = '{1'b1, 1'b1, 2'd2, 2'd1, 1'b1, 2'd1, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 2'd2, 2'd3, 1'b0, 2'd2, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 2'd0, 1'b0, 2'd1, 32'h1234_5678};

        reset_n       = 1'b0;
        m0_read       = 1'b0;
        m1_read       = 1'b0;
        m0_address    = '0;
        m1_address    = '0;
        l3_m0_read    = 1'b0;
        l3_m1_read    = 1'b0;
        l3_m0_address = '0;
        l3_m1_address = '0;
        #2;
        do_reset();

        // Both masters held from reset: strict alternation, 4-cycle spacing.
        m0_read    = 1'b1;
        m1_read    = 1'b1;
        m0_address = 2'd1;
        m1_address = 2'd3;
        for (int t = 0; t < 6; t++) begin
            logic [1:0] ea;
            ea = t[0] ? 2'd3 : 2'd1;
            wait_done(cyc);
            check_xact($sformatf("contend%0d", t), t[0], ea,
                       slave_word(ea), (t == 0) ? 3 : 4, cyc);
        end
        m0_read = 1'b0;
        m1_read = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            m0_read    = vecs[i].r0;
            m1_read    = vecs[i].r1;
            m0_address = vecs[i].a0;
            m1_address = vecs[i].a1;
            wait_done(cyc);
            check_xact($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ea,
                       vecs[i].ed, 3, cyc);
            m0_read = 1'b0;
            m1_read = 1'b0;
            step();
        end

        // Reset while in WAIT: no pulse, back to reset values.
        m1_read    = 1'b1;
        m1_address = 2'd3;
        step();
        step();
        reset_n = 1'b0;
        m1_read = 1'b0;
        #1;
        check("midrst_m0_wr", 32'(m0_wr), 32'(1));
        check("midrst_m1_wr", 32'(m1_wr), 32'(1));
        check("midrst_saddr", 32'(s_address), 32'(0));
        check("midrst_grant", 32'(grant), 32'(0));
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (!m0_wr || !m1_wr) lows++;
        end
        reset_n = 1'b1;
        step();
        if (!m0_wr || !m1_wr) lows++;
        check("midrst_no_pulse", 32'(lows), 32'(0));
        m0_read    = 1'b1;
        m0_address = 2'd1;
        wait_done(cyc);
        check_xact("postrst", 1'b0, 2'd1, 32'h1234_5678, 3, cyc);
        m0_read = 1'b0;
        step();

        // m1 drops read during ADDR: transaction still completes.
        m1_read    = 1'b1;
        m1_address = 2'd2;
        step();
        m1_read = 1'b0;
        wait_done(cyc);
        check_xact("drop", 1'b1, 2'd2, 32'hDEAD_BEEF, 3, cyc + 1);
        step();
        m0_read    = 1'b1;
        m0_address = 2'd0;
        wait_done(cyc);
        check_xact("after_drop", 1'b0, 2'd0, 32'h0000_00A5, 3, cyc);
        m0_read = 1'b0;
        step();

        // Slave latency 3: address held ADDR..DONE, pulse at T+5.
        l3_m1_read    = 1'b1;
        l3_m1_address = 2'd2;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k <= 5) begin
                check($sformatf("l3_saddr%0d", k), 32'(l3_s_address), 32'(2));
            end
            check($sformatf("l3_m1_wr%0d", k), 32'(l3_m1_wr),
                  32'((k == 5) ? 0 : 1));
            check($sformatf("l3_m0_wr%0d", k), 32'(l3_m0_wr), 32'(1));
            if (k == 5) begin
                check("l3_data", l3_m1_rd, 32'hDEAD_BEEF);
                check("l3_grant", 32'(l3_grant), 32'(1));
                l3_m1_read = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
